// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants so the sync generator and the animation
// blocks agree on screen bounds, totals and sync polarity.
package vga_timing_pkg;

   localparam int CNT_W = 10;
   typedef logic [CNT_W-1:0] coord_t;

   localparam int CLK_DIV_DEF = 4;

   localparam int H_DISPLAY_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int H_TOTAL_DEF   = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

   localparam int V_DISPLAY_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;
   localparam int V_TOTAL_DEF   = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   localparam logic SYNC_ACTIVE_DEF = 1'b0;

   // Half-open window test used for both sync pulses: lo <= cnt < hi.
   function automatic logic in_window(coord_t cnt, coord_t lo, coord_t hi);
      return (cnt >= lo) && (cnt < hi);
   endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Modulo-CLK_DIV counter. 'advance' is high in the clk before each pixel step;
// pix_tick is its registered copy, so both line up on the edge the raster moves.
module pixel_tick_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic advance,
   output logic pix_tick
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             pix_tick_q, pix_tick_d;

   always_comb begin
      advance    = (div_q == DIV_LAST);
      div_d      = advance ? '0 : div_q + 1'b1;
      pix_tick_d = advance;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q      <= '0;
         pix_tick_q <= 1'b0;
      end else begin
         div_q      <= div_d;
         pix_tick_q <= pix_tick_d;
      end
   end

   assign pix_tick = pix_tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing source: pixel/line counters, registered video/sync decode,
// once-per-frame tick and frame counter, and the blanked colour register.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int   CLK_DIV     = CLK_DIV_DEF,
   parameter int   H_DISPLAY   = H_DISPLAY_DEF,
   parameter int   H_FRONT     = H_FRONT_DEF,
   parameter int   H_SYNC      = H_SYNC_DEF,
   parameter int   H_BACK      = H_BACK_DEF,
   parameter int   V_DISPLAY   = V_DISPLAY_DEF,
   parameter int   V_FRONT     = V_FRONT_DEF,
   parameter int   V_SYNC      = V_SYNC_DEF,
   parameter int   V_BACK      = V_BACK_DEF,
   parameter logic SYNC_ACTIVE = SYNC_ACTIVE_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] rgb_in,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       h_video,
   output logic       v_video,
   output logic       pix_tick,
   output logic       tick60hz,
   output logic       hsync,
   output logic       vsync,
   output logic [2:0] rgb_out,
   output logic [7:0] frame_cnt
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
   localparam coord_t H_VIS_END  = coord_t'(H_DISPLAY);
   localparam coord_t V_VIS_END  = coord_t'(V_DISPLAY);
   localparam coord_t HS_START   = coord_t'(H_DISPLAY + H_FRONT);
   localparam coord_t HS_END     = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam coord_t VS_START   = coord_t'(V_DISPLAY + V_FRONT);
   localparam coord_t VS_END     = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

   logic advance;

   coord_t     h_cnt_q, h_cnt_d;
   coord_t     v_cnt_q, v_cnt_d;
   logic       h_video_q, h_video_d;
   logic       v_video_q, v_video_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       tick60_q, tick60_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic [2:0] rgb_q, rgb_d;

   pixel_tick_div #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .clk      (clk),
      .reset    (reset),
      .advance  (advance),
      .pix_tick (pix_tick)
   );

   // The frame tick fires only on the line wrap that lands on the first blank line.
   always_comb begin
      h_cnt_d     = h_cnt_q;
      v_cnt_d     = v_cnt_q;
      tick60_d    = 1'b0;
      frame_cnt_d = frame_cnt_q;
      if (advance) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            if (v_cnt_d == V_VIS_END) begin
               tick60_d    = 1'b1;
               frame_cnt_d = frame_cnt_q + 1'b1;
            end
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
         end
      end
   end

   // Decoding from next-state counts keeps these flops aligned with pix_x/pix_y.
   always_comb begin
      h_video_d = (h_cnt_d < H_VIS_END);
      v_video_d = (v_cnt_d < V_VIS_END);
      hsync_d   = in_window(h_cnt_d, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d   = in_window(v_cnt_d, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      rgb_d     = (h_video_q && v_video_q) ? rgb_in : 3'b000;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         h_video_q   <= 1'b1;
         v_video_q   <= 1'b1;
         hsync_q     <= ~SYNC_ACTIVE;
         vsync_q     <= ~SYNC_ACTIVE;
         tick60_q    <= 1'b0;
         frame_cnt_q <= '0;
         rgb_q       <= 3'b000;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         h_video_q   <= h_video_d;
         v_video_q   <= v_video_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         tick60_q    <= tick60_d;
         frame_cnt_q <= frame_cnt_d;
         rgb_q       <= rgb_d;
      end
   end

   assign pix_x     = h_cnt_q;
   assign pix_y     = v_cnt_q;
   assign h_video   = h_video_q;
   assign v_video   = v_video_q;
   assign hsync     = hsync_q;
   assign vsync     = vsync_q;
   assign tick60hz  = tick60_q;
   assign frame_cnt = frame_cnt_q;
   assign rgb_out   = rgb_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two shrunken rasters (CLK_DIV=4 and CLK_DIV=1) checked
// against a closed-form model of where the raster is after k clocks.
module tb_vga_sync_gen;

   typedef struct packed {
      int   div; int hd; int hf; int hs; int hb;
      int   vd;  int vf; int vs; int vb;
      logic sa;
   } cfg_t;

   localparam cfg_t CFG1 = '{div: 4, hd: 16, hf: 2, hs: 4, hb: 3,
                             vd: 8, vf: 2, vs: 2, vb: 3, sa: 1'b0};
   localparam cfg_t CFG2 = '{div: 1, hd: 4, hf: 1, hs: 2, hb: 1,
                             vd: 3, vf: 1, vs: 1, vb: 1, sa: 1'b1};

   typedef struct packed {
      logic [9:0] pix_x;
      logic [9:0] pix_y;
      logic       h_video;
      logic       v_video;
      logic       pix_tick;
      logic       tick60hz;
      logic       hsync;
      logic       vsync;
      logic [7:0] frame_cnt;
   } state_t;

   typedef struct {
      int     cycle;
      state_t exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset1, reset2;
   logic [2:0] rgb_in;

   logic [9:0] pix_x1, pix_y1, pix_x2, pix_y2;
   logic       h_video1, v_video1, pix_tick1, tick1, hsync1, vsync1;
   logic       h_video2, v_video2, pix_tick2, tick2, hsync2, vsync2;
   logic [2:0] rgb_out1, rgb_out2;
   logic [7:0] frame_cnt1, frame_cnt2;

   int         compared = 0;
   int         mismatched = 0;
   int         k1, k2;
   logic [2:0] exp_rgb1, exp_rgb2;
   logic       chk2_en = 1'b0;
   int         ticks2 = 0;

   vec_t       vecs [18];

   always #5 clk = ~clk;

   vga_sync_gen #(
      .CLK_DIV(4), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
      .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_ACTIVE(1'b0)
   ) dut1 (
      .clk(clk), .reset(reset1), .rgb_in(rgb_in),
      .pix_x(pix_x1), .pix_y(pix_y1), .h_video(h_video1), .v_video(v_video1),
      .pix_tick(pix_tick1), .tick60hz(tick1), .hsync(hsync1), .vsync(vsync1),
      .rgb_out(rgb_out1), .frame_cnt(frame_cnt1)
   );

   vga_sync_gen #(
      .CLK_DIV(1), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_ACTIVE(1'b1)
   ) dut2 (
      .clk(clk), .reset(reset2), .rgb_in(rgb_in),
      .pix_x(pix_x2), .pix_y(pix_y2), .h_video(h_video2), .v_video(v_video2),
      .pix_tick(pix_tick2), .tick60hz(tick2), .hsync(hsync2), .vsync(vsync2),
      .rgb_out(rgb_out2), .frame_cnt(frame_cnt2)
   );

   // After k clocks the raster has taken k/div pixel steps; everything follows from that.
   function automatic state_t model(int k, cfg_t c);
      state_t s;
      int ht, vt, n, h, v, fr, first;
      ht    = c.hd + c.hf + c.hs + c.hb;
      vt    = c.vd + c.vf + c.vs + c.vb;
      n     = k / c.div;
      h     = n % ht;
      v     = (n / ht) % vt;
      fr    = ht * vt;
      first = c.vd * ht;
      s.pix_x     = 10'(h);
      s.pix_y     = 10'(v);
      s.h_video   = (h < c.hd);
      s.v_video   = (v < c.vd);
      s.pix_tick  = (k > 0) && (k % c.div == 0);
      s.tick60hz  = s.pix_tick && (n % fr == first);
      s.hsync     = (h >= c.hd + c.hf && h < c.hd + c.hf + c.hs) ? c.sa : ~c.sa;
      s.vsync     = (v >= c.vd + c.vf && v < c.vd + c.vf + c.vs) ? c.sa : ~c.sa;
      s.frame_cnt = (n >= first) ? 8'(((n - first) / fr + 1) % 256) : 8'd0;
      return s;
   endfunction

   function automatic logic model_vis(int k, cfg_t c);
      state_t s;
      s = model(k, c);
      return s.h_video & s.v_video;
   endfunction

   function automatic vec_t mk(int cyc, int px, int py, logic hv, logic vv, logic pt,
                               logic t60, logic hs, logic vs, int fc);
      vec_t r;
      r.cycle = cyc;
      r.exp   = '{pix_x: 10'(px), pix_y: 10'(py), h_video: hv, v_video: vv,
                  pix_tick: pt, tick60hz: t60, hsync: hs, vsync: vs, frame_cnt: 8'(fc)};
      return r;
   endfunction

   function automatic state_t grab1();
      return '{pix_x: pix_x1, pix_y: pix_y1, h_video: h_video1, v_video: v_video1,
               pix_tick: pix_tick1, tick60hz: tick1, hsync: hsync1, vsync: vsync1,
               frame_cnt: frame_cnt1};
   endfunction

   function automatic state_t grab2();
      return '{pix_x: pix_x2, pix_y: pix_y2, h_video: h_video2, v_video: v_video2,
               pix_tick: pix_tick2, tick60hz: tick2, hsync: hsync2, vsync: vsync2,
               frame_cnt: frame_cnt2};
   endfunction

   // Clock counters and expected colour register, cleared by the same async resets as the DUTs.
   always @(posedge clk or posedge reset1) begin
      if (reset1) begin
         k1       <= 0;
         exp_rgb1 <= 3'b000;
      end else begin
         exp_rgb1 <= model_vis(k1, CFG1) ? rgb_in : 3'b000;
         k1       <= k1 + 1;
      end
   end

   always @(posedge clk or posedge reset2) begin
      if (reset2) begin
         k2       <= 0;
         exp_rgb2 <= 3'b000;
      end else begin
         exp_rgb2 <= model_vis(k2, CFG2) ? rgb_in : 3'b000;
         k2       <= k2 + 1;
      end
   end

   task automatic cmp(input string what, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", what, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input string tag, input state_t act, input state_t exp);
      cmp({tag, ".pix_x"},     32'(act.pix_x),     32'(exp.pix_x));
      cmp({tag, ".pix_y"},     32'(act.pix_y),     32'(exp.pix_y));
      cmp({tag, ".h_video"},   32'(act.h_video),   32'(exp.h_video));
      cmp({tag, ".v_video"},   32'(act.v_video),   32'(exp.v_video));
      cmp({tag, ".pix_tick"},  32'(act.pix_tick),  32'(exp.pix_tick));
      cmp({tag, ".tick60hz"},  32'(act.tick60hz),  32'(exp.tick60hz));
      cmp({tag, ".hsync"},     32'(act.hsync),     32'(exp.hsync));
      cmp({tag, ".vsync"},     32'(act.vsync),     32'(exp.vsync));
      cmp({tag, ".frame_cnt"}, 32'(act.frame_cnt), 32'(exp.frame_cnt));
   endtask

   task automatic applyStimulus(input logic [2:0] rgb);
      @(negedge clk);
      rgb_in = rgb;
   endtask

   // The CLK_DIV=1 instance is checked every cycle while the main sequence runs.
   always @(negedge clk) begin
      if (chk2_en) begin
         checkOutput("dut2", grab2(), model(k2, CFG2));
         cmp("dut2.rgb_out", 32'(rgb_out2), 32'(exp_rgb2));
         if (tick2) ticks2++;
      end
   end

   initial begin
      #10_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      state_t st;
      int     hs_low0, hs_first, vs_low, tick_cnt;
      int     tick_k [2];

      vecs[0]  = mk(3,    0,  0, 1, 1, 0, 0, 1, 1, 0);
      vecs[1]  = mk(4,    1,  0, 1, 1, 1, 0, 1, 1, 0);
      vecs[2]  = mk(5,    1,  0, 1, 1, 0, 0, 1, 1, 0);
      vecs[3]  = mk(8,    2,  0, 1, 1, 1, 0, 1, 1, 0);
      vecs[4]  = mk(64,  16,  0, 0, 1, 1, 0, 1, 1, 0);
      vecs[5]  = mk(72,  18,  0, 0, 1, 1, 0, 0, 1, 0);
      vecs[6]  = mk(87,  21,  0, 0, 1, 0, 0, 0, 1, 0);
      vecs[7]  = mk(88,  22,  0, 0, 1, 1, 0, 1, 1, 0);
      vecs[8]  = mk(96,  24,  0, 0, 1, 1, 0, 1, 1, 0);
      vecs[9]  = mk(100,  0,  1, 1, 1, 1, 0, 1, 1, 0);
      vecs[10] = mk(799, 24,  7, 0, 1, 0, 0, 1, 1, 0);
      vecs[11] = mk(800,  0,  8, 1, 0, 1, 1, 1, 1, 1);
      vecs[12] = mk(801,  0,  8, 1, 0, 0, 0, 1, 1, 1);
      vecs[13] = mk(1000, 0, 10, 1, 0, 1, 0, 1, 0, 1);
      vecs[14] = mk(1199, 24, 11, 0, 0, 0, 0, 1, 0, 1);
      vecs[15] = mk(1200, 0, 12, 1, 0, 1, 0, 1, 1, 1);
      vecs[16] = mk(1500, 0,  0, 1, 1, 1, 0, 1, 1, 1);
      vecs[17] = mk(2300, 0,  8, 1, 0, 1, 1, 1, 1, 2);

      rgb_in = 3'b101;
      reset1 = 1'b1;
      reset2 = 1'b1;
      repeat (3) @(negedge clk);

      checkOutput("reset", grab1(), model(0, CFG1));
      cmp("reset.rgb_out", 32'(rgb_out1), 32'd0);

      reset1  = 1'b0;
      reset2  = 1'b0;
      chk2_en = 1'b1;

      $display("[TB] hand-derived checkpoints, rgb_in = 101");
      for (int i = 0; i < 18; i++) begin
         for (int w = 0; w < 5000 && k1 < vecs[i].cycle; w++) applyStimulus(3'b101);
         checkOutput($sformatf("vec%0d", vecs[i].cycle), grab1(), vecs[i].exp);
         cmp($sformatf("vec%0d.rgb_out", vecs[i].cycle), 32'(rgb_out1), 32'(exp_rgb1));
      end

      $display("[TB] two frames of random colour against the model");
      reset1 = 1'b1;
      @(negedge clk);
      reset1   = 1'b0;
      hs_low0  = 0;
      hs_first = -1;
      vs_low   = 0;
      tick_cnt = 0;
      tick_k[0] = 0;
      tick_k[1] = 0;
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(3'($urandom_range(0, 7)));
         st = grab1();
         checkOutput("rand", st, model(k1, CFG1));
         cmp("rand.rgb_out", 32'(rgb_out1), 32'(exp_rgb1));
         if (tick_cnt == 0 && st.pix_y == 10'd0 && st.hsync == CFG1.sa) begin
            if (hs_low0 == 0) hs_first = int'(st.pix_x);
            hs_low0++;
         end
         if (st.vsync == CFG1.sa) vs_low++;
         if (st.tick60hz) begin
            if (tick_cnt < 2) tick_k[tick_cnt] = k1;
            tick_cnt++;
         end
      end
      cmp("hsync_low_clks", 32'(hs_low0), 32'd16);
      cmp("hsync_start_x", 32'(hs_first), 32'd18);
      cmp("vsync_low_clks", 32'(vs_low), 32'd400);
      cmp("tick_count", 32'(tick_cnt), 32'd2);
      cmp("tick_spacing", 32'(tick_k[1] - tick_k[0]), 32'd1500);
      cmp("frame_cnt_after_2", 32'(frame_cnt1), 32'd2);

      $display("[TB] asynchronous reset mid-frame");
      for (int w = 0; w < 2000; w++) begin
         st = model(k1, CFG1);
         if (st.pix_x == 10'd10 && st.pix_y == 10'd4) break;
         applyStimulus(3'($urandom_range(0, 7)));
      end
      cmp("midframe.pix_x", 32'(pix_x1), 32'd10);
      cmp("midframe.pix_y", 32'(pix_y1), 32'd4);
      #2 reset1 = 1'b1;
      #1;
      checkOutput("async_reset", grab1(), model(0, CFG1));
      cmp("async_reset.rgb_out", 32'(rgb_out1), 32'd0);
      @(negedge clk);
      reset1 = 1'b0;
      for (int i = 0; i < 200; i++) begin
         applyStimulus(3'($urandom_range(0, 7)));
         checkOutput("post_reset", grab1(), model(k1, CFG1));
         cmp("post_reset.rgb_out", 32'(rgb_out1), 32'(exp_rgb1));
      end

      $display("[TB] waiting for the CLK_DIV=1 instance to complete 256 frames");
      for (int w = 0; w < 20000 && k2 < 12300; w++) applyStimulus(3'($urandom_range(0, 7)));
      chk2_en = 1'b0;
      cmp("dut2.k_reached", 32'(k2 >= 12300), 32'd1);
      cmp("dut2.tick_count", 32'(ticks2), 32'd256);
      cmp("dut2.frame_cnt_wrapped", 32'(frame_cnt2), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
